// File: rtl/l2_data_array_nway.sv
// N-way byte-maskable L2 data store with 1- or 2-cycle read latency and a
// hardware sweeper that zeroes every set after reset or on a clear pulse.
module l2_data_array_nway #(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int s_way    = 2,
    parameter int read_lat = 1,
    localparam int s_mask  = 2**s_offset,
    localparam int s_line  = 8*s_mask
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                read,
    input  logic [s_index-1:0]  rindex,
    input  logic [s_way-1:0]    rway,
    input  logic [s_mask-1:0]   write_en,
    input  logic [s_index-1:0]  windex,
    input  logic [s_way-1:0]    wway,
    input  logic [s_line-1:0]   datain,
    input  logic                clear,
    output logic [s_line-1:0]   dataout,
    output logic                rvalid,
    output logic                busy
);

    localparam int num_sets = 2**s_index;
    localparam int num_ways = 2**s_way;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [s_index-1:0]  r_ptr;
    logic [s_index-1:0]  w_ptr_next;
    logic [s_line-1:0]   r_mem [num_sets][num_ways];
    logic [s_line-1:0]   w_rdata;
    logic [s_line-1:0]   r_dataout;
    logic                r_rvalid;
    logic                w_busy;
    logic                w_rd_accept;
    logic                w_same_line;

    assign w_busy      = (r_state == SWEEP);
    assign w_rd_accept = read & ~w_busy;
    assign w_same_line = (rindex == windex) && (rway == wway);
    assign busy        = w_busy;
    assign dataout     = r_dataout;
    assign rvalid      = r_rvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SWEEP;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    // A clear pulse during a sweep is deliberately ignored rather than restarting it.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        case (r_state)
            IDLE: begin
                if (clear) begin
                    w_state_next = SWEEP;
                    w_ptr_next   = '0;
                end
            end
            SWEEP: begin
                w_ptr_next = r_ptr + s_index'(1);
                if (r_ptr == s_index'(num_sets - 1)) begin
                    w_state_next = IDLE;
                    w_ptr_next   = '0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_ptr_next   = '0;
            end
        endcase
    end

    // Storage has no reset; the sweeper is the only thing that initialises it.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            for (int w = 0; w < num_ways; w++) begin
                r_mem[r_ptr][w] <= '0;
            end
        end else begin
            for (int i = 0; i < s_mask; i++) begin
                if (write_en[i]) begin
                    r_mem[windex][wway][8*i +: 8] <= datain[8*i +: 8];
                end
            end
        end
    end

    // Same-edge write to the line being read forwards only the masked bytes.
    always_comb begin
        w_rdata = r_mem[rindex][rway];
        if (!w_busy && w_same_line) begin
            for (int i = 0; i < s_mask; i++) begin
                if (write_en[i]) begin
                    w_rdata[8*i +: 8] = datain[8*i +: 8];
                end
            end
        end
    end

    generate
        if (read_lat == 1) begin : g_lat1
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_dataout <= '0;
                    r_rvalid  <= 1'b0;
                end else begin
                    r_rvalid <= w_rd_accept;
                    if (w_rd_accept) begin
                        r_dataout <= w_rdata;
                    end
                end
            end
        end else begin : g_lat2
            logic [s_line-1:0] r_pipe_data;
            logic              r_pipe_valid;

            // The second stage is not gated by busy so reads accepted before a sweep still retire.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pipe_data  <= '0;
                    r_pipe_valid <= 1'b0;
                    r_dataout    <= '0;
                    r_rvalid     <= 1'b0;
                end else begin
                    r_pipe_valid <= w_rd_accept;
                    if (w_rd_accept) begin
                        r_pipe_data <= w_rdata;
                    end
                    r_rvalid <= r_pipe_valid;
                    if (r_pipe_valid) begin
                        r_dataout <= r_pipe_data;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_l2_data_array_nway.sv
// Self-checking bench: one instance per read latency sharing all inputs,
// a table of single-cycle vectors plus hand-written sweep and latency sequences.
module tb_l2_data_array_nway;

    logic         clk = 1'b0;
    logic         rst;
    logic         read;
    logic [2:0]   rindex;
    logic [1:0]   rway;
    logic [31:0]  write_en;
    logic [2:0]   windex;
    logic [1:0]   wway;
    logic [255:0] datain;
    logic         clear;
    logic [255:0] dataout1, dataout2;
    logic         rvalid1, rvalid2, busy1, busy2;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic         rd;
        logic [2:0]   ri;
        logic [1:0]   rw;
        logic [31:0]  we;
        logic [2:0]   wi;
        logic [1:0]   ww;
        logic [255:0] di;
        logic         expValid;
        logic [255:0] expData;
    } vec_t;

    vec_t vecs [14];
    int   nVec = 0;

    always #5 clk = ~clk;

    l2_data_array_nway #(.s_offset(5), .s_index(3), .s_way(2), .read_lat(1)) dut1 (
        .clk(clk), .rst(rst), .read(read), .rindex(rindex), .rway(rway),
        .write_en(write_en), .windex(windex), .wway(wway), .datain(datain),
        .clear(clear), .dataout(dataout1), .rvalid(rvalid1), .busy(busy1)
    );

    l2_data_array_nway #(.s_offset(5), .s_index(3), .s_way(2), .read_lat(2)) dut2 (
        .clk(clk), .rst(rst), .read(read), .rindex(rindex), .rway(rway),
        .write_en(write_en), .windex(windex), .wway(wway), .datain(datain),
        .clear(clear), .dataout(dataout2), .rvalid(rvalid2), .busy(busy2)
    );

    function automatic logic [255:0] fill(input logic [7:0] b);
        return {32{b}};
    endfunction

    // Bytes below n carry lo, the rest carry hi.
    function automatic logic [255:0] mix(input logic [7:0] lo, input logic [7:0] hi, input int n);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = (i < n) ? lo : hi;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic [2:0] ri, input logic [1:0] rw,
                                 input logic [31:0] we, input logic [2:0] wi, input logic [1:0] ww,
                                 input logic [255:0] di);
        read     = rd;
        rindex   = ri;
        rway     = rw;
        write_en = we;
        windex   = wi;
        wway     = ww;
        datain   = di;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 3'd0, 2'd0, 32'h0, 3'd0, 2'd0, '0);
    endtask

    task automatic addVec(input logic rd, input logic [2:0] ri, input logic [1:0] rw,
                          input logic [31:0] we, input logic [2:0] wi, input logic [1:0] ww,
                          input logic [255:0] di, input logic ev, input logic [255:0] ed);
        vecs[nVec].rd       = rd;
        vecs[nVec].ri       = ri;
        vecs[nVec].rw       = rw;
        vecs[nVec].we       = we;
        vecs[nVec].wi       = wi;
        vecs[nVec].ww       = ww;
        vecs[nVec].di       = di;
        vecs[nVec].expValid = ev;
        vecs[nVec].expData  = ed;
        nVec++;
    endtask

    // After reset release or a clear, busy must stay high for exactly eight edges.
    task automatic checkResetSweep(input string tag);
        for (int k = 1; k <= 8; k++) begin
            step();
            checkOutput($sformatf("%s busy1 edge%0d", tag, k), busy1, (k < 8));
            checkOutput($sformatf("%s busy2 edge%0d", tag, k), busy2, (k < 8));
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [255:0] held2;
        logic [255:0] prevData;
        logic         prevValid;
        logic [7:0]   b;

        // Reset state and power-up sweep
        rst   = 1'b1;
        clear = 1'b0;
        idleInputs();
        #2;
        checkOutput("reset busy1", busy1, 1'b1);
        checkOutput("reset rvalid1", rvalid1, 1'b0);
        checkOutput("reset dataout1", dataout1, '0);
        checkOutput("reset rvalid2", rvalid2, 1'b0);
        checkOutput("reset dataout2", dataout2, '0);
        step();
        step();
        rst = 1'b0;
        checkResetSweep("powerup");
        applyStimulus(1'b1, 3'd5, 2'd1, 32'h0, 3'd0, 2'd0, '0);
        step();
        checkOutput("first read rvalid1", rvalid1, 1'b1);
        checkOutput("first read dataout1", dataout1, '0);
        checkOutput("first read rvalid2 early", rvalid2, 1'b0);
        idleInputs();
        step();
        checkOutput("first read rvalid1 drop", rvalid1, 1'b0);
        checkOutput("first read rvalid2", rvalid2, 1'b1);
        checkOutput("first read dataout2", dataout2, '0);
        step();
        checkOutput("first read rvalid2 drop", rvalid2, 1'b0);

        // Table-driven single-cycle vectors (expected values for latency 1)
        addVec(0, 3'd0, 2'd0, 32'h0000_00FF, 3'd3, 2'd2, fill(8'hAA), 0, '0);
        addVec(1, 3'd3, 2'd2, 32'h0,         3'd0, 2'd0, '0,          1, mix(8'hAA, 8'h00, 8));
        addVec(1, 3'd3, 2'd0, 32'h0,         3'd0, 2'd0, '0,          1, '0);
        addVec(1, 3'd3, 2'd1, 32'h0,         3'd0, 2'd0, '0,          1, '0);
        addVec(1, 3'd3, 2'd3, 32'h0,         3'd0, 2'd0, '0,          1, '0);
        addVec(0, 3'd0, 2'd0, 32'hFFFF_FFFF, 3'd1, 2'd0, fill(8'h11), 0, '0);
        addVec(1, 3'd1, 2'd0, 32'h0000_000F, 3'd1, 2'd0, fill(8'h22), 1, mix(8'h22, 8'h11, 4));
        addVec(1, 3'd1, 2'd0, 32'h0,         3'd0, 2'd0, '0,          1, mix(8'h22, 8'h11, 4));
        addVec(1, 3'd6, 2'd2, 32'hFFFF_FFFF, 3'd6, 2'd3, fill(8'h33), 1, '0);
        addVec(1, 3'd6, 2'd3, 32'hFFFF_FFFF, 3'd2, 2'd1, fill(8'h44), 1, fill(8'h33));
        addVec(1, 3'd2, 2'd1, 32'h0,         3'd0, 2'd0, '0,          1, fill(8'h44));
        addVec(1, 3'd2, 2'd1, 32'h0,         3'd2, 2'd1, fill(8'hFF), 1, fill(8'h44));
        addVec(1, 3'd2, 2'd1, 32'h8000_0000, 3'd2, 2'd1, fill(8'h55), 1, mix(8'h44, 8'h55, 31));
        addVec(0, 3'd0, 2'd0, 32'h0,         3'd0, 2'd0, '0,          0, mix(8'h44, 8'h55, 31));

        held2     = '0;
        prevValid = 1'b0;
        prevData  = '0;
        for (int v = 0; v < nVec; v++) begin
            applyStimulus(vecs[v].rd, vecs[v].ri, vecs[v].rw, vecs[v].we,
                          vecs[v].wi, vecs[v].ww, vecs[v].di);
            step();
            checkOutput($sformatf("vec%0d rvalid1", v), rvalid1, vecs[v].expValid);
            checkOutput($sformatf("vec%0d dataout1", v), dataout1, vecs[v].expData);
            if (prevValid) held2 = prevData;
            checkOutput($sformatf("vec%0d rvalid2", v), rvalid2, prevValid);
            checkOutput($sformatf("vec%0d dataout2", v), dataout2, held2);
            prevValid = vecs[v].expValid;
            prevData  = vecs[v].expData;
        end
        idleInputs();

        // Latency: four back-to-back reads to the four ways of set 3
        for (int w = 0; w < 4; w++) begin
            applyStimulus(1'b0, 3'd0, 2'd0, 32'hFFFF_FFFF, 3'd3, 2'(w), fill(8'(8'h50 + w)));
            step();
        end
        for (int c = 0; c < 6; c++) begin
            if (c < 4) applyStimulus(1'b1, 3'd3, 2'(c), 32'h0, 3'd0, 2'd0, '0);
            else idleInputs();
            step();
            checkOutput($sformatf("lat c%0d rvalid1", c), rvalid1, (c < 4));
            checkOutput($sformatf("lat c%0d dataout1", c), dataout1,
                        fill(8'(8'h50 + ((c < 4) ? c : 3))));
            checkOutput($sformatf("lat c%0d rvalid2", c), rvalid2, (c >= 1 && c <= 4));
            checkOutput($sformatf("lat c%0d dataout2", c), dataout2,
                        (c == 0) ? mix(8'h44, 8'h55, 31) : fill(8'(8'h50 + ((c - 1 < 4) ? c - 1 : 3))));
        end

        // Clear sweep: fill everything, clear with an in-flight read, poke at sweep edge 2
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 4; w++) begin
                applyStimulus(1'b0, 3'd0, 2'd0, 32'hFFFF_FFFF, 3'(s), 2'(w), fill(8'(s*4 + w + 1)));
                step();
            end
        end
        applyStimulus(1'b1, 3'd5, 2'd1, 32'h0, 3'd0, 2'd0, '0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        idleInputs();
        checkOutput("clear edge busy1", busy1, 1'b1);
        checkOutput("clear edge rvalid1", rvalid1, 1'b1);
        checkOutput("clear edge dataout1", dataout1, fill(8'h16));
        step();
        checkOutput("sweep1 rvalid1", rvalid1, 1'b0);
        checkOutput("sweep1 inflight rvalid2", rvalid2, 1'b1);
        checkOutput("sweep1 inflight dataout2", dataout2, fill(8'h16));
        applyStimulus(1'b1, 3'd5, 2'd1, 32'hFFFF_FFFF, 3'd0, 2'd0, fill(8'hFF));
        step();
        idleInputs();
        checkOutput("sweep2 ignored rvalid1", rvalid1, 1'b0);
        checkOutput("sweep2 dataout1 held", dataout1, fill(8'h16));
        step();
        checkOutput("sweep3 ignored rvalid2", rvalid2, 1'b0);
        for (int k = 4; k <= 8; k++) begin
            clear = (k == 4);
            step();
            checkOutput($sformatf("sweep%0d busy1", k), busy1, (k < 8));
        end
        clear = 1'b0;
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 4; w++) begin
                applyStimulus(1'b1, 3'(s), 2'(w), 32'h0, 3'd0, 2'd0, '0);
                step();
                checkOutput($sformatf("cleared s%0d w%0d rvalid1", s, w), rvalid1, 1'b1);
                checkOutput($sformatf("cleared s%0d w%0d dataout1", s, w), dataout1, '0);
            end
        end
        idleInputs();
        step();

        // Reset in the middle of a sweep restarts it from set 0
        b = 8'h77;
        applyStimulus(1'b0, 3'd0, 2'd0, 32'hFFFF_FFFF, 3'd4, 2'd2, fill(b));
        step();
        applyStimulus(1'b1, 3'd4, 2'd2, 32'h0, 3'd0, 2'd0, '0);
        step();
        checkOutput("pre-rst dataout1", dataout1, fill(b));
        idleInputs();
        clear = 1'b1;
        step();
        clear = 1'b0;
        checkOutput("pre-rst dataout2", dataout2, fill(b));
        for (int k = 1; k <= 5; k++) step();
        rst = 1'b1;
        #1;
        checkOutput("async rst dataout1", dataout1, '0);
        checkOutput("async rst dataout2", dataout2, '0);
        checkOutput("async rst busy1", busy1, 1'b1);
        step();
        rst = 1'b0;
        checkResetSweep("midsweep");
        applyStimulus(1'b1, 3'd4, 2'd2, 32'h0, 3'd0, 2'd0, '0);
        step();
        idleInputs();
        checkOutput("post-rst rvalid1", rvalid1, 1'b1);
        checkOutput("post-rst dataout1", dataout1, '0);
        step();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
